// File: rtl/seq_detect_scheduler.sv
// Shared serial-pattern detector, time-multiplexed over NCH bit-stream requesters.
// A round-robin arbiter feeds one bit per cycle; each channel keeps its own detection context.
module seq_detect_scheduler #(
  parameter int NCH      = 4,
  parameter int PLEN_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [PLEN_MAX-1:0] cfg_pattern,
  input  logic [3:0]          cfg_len,
  input  logic                cfg_overlap,
  output logic                cfg_err,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH-1:0]      req_bit,
  output logic [NCH-1:0]      req_ready,
  output logic                match_valid,
  output logic [2:0]          match_ch,
  input  logic [2:0]          cnt_sel,
  output logic [CNT_W-1:0]    cnt_out
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW    = $clog2(PLEN_MAX + 1);

  logic [PLEN_MAX-1:0] pattern_q;
  logic [3:0]          len_q;
  logic                overlap_q;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PLEN_MAX-1:0] hist_q  [NCH];
  logic [SW-1:0]       since_q [NCH];
  logic [CNT_W-1:0]    cnt_q   [NCH];
  logic                match_valid_q, match_valid_d;
  logic [2:0]          match_ch_q, match_ch_d;
  logic                cfg_err_q, cfg_err_d;

  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic                len_ok;
  logic [PLEN_MAX-1:0] hist_new, len_mask;
  logic [SW-1:0]       since_new;
  logic                hit;

  // Handshake: channel g transfers req_bit[g] at a rising edge where req_valid[g] & req_ready[g];
  // req_ready is one-hot or zero, never depends on req_bit, and is held low during a config write.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (cfg_we || rst) grant_any = 1'b0;
  end

  assign req_ready = grant_any ? (NCH'(1) << grant_idx) : '0;
  assign len_ok    = (cfg_len != 4'd0) && (32'(cfg_len) <= PLEN_MAX);

  // Context of the granted channel after absorbing its bit; match is judged on this.
  always_comb begin
    hist_new  = {hist_q[grant_idx][PLEN_MAX-2:0], req_bit[grant_idx]};
    since_new = (32'(since_q[grant_idx]) >= PLEN_MAX) ? SW'(PLEN_MAX)
                                                      : since_q[grant_idx] + SW'(1);
    for (int i = 0; i < PLEN_MAX; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = grant_any && (((hist_new ^ pattern_q) & len_mask) == '0)
                    && (32'(since_new) >= 32'(len_q));
  end

  always_comb begin
    match_valid_d = hit;
    match_ch_d    = hit ? 3'(grant_idx) : match_ch_q;
    cfg_err_d     = cfg_we && !len_ok;
    ptr_d         = ptr_q;
    if (cfg_we && len_ok) begin
      ptr_d = '0;
    end else if (grant_any) begin
      ptr_d = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q     <= PLEN_MAX'(4'b1010);
      len_q         <= 4'd4;
      overlap_q     <= 1'b0;
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      cfg_err_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i]  <= '0;
        since_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      cfg_err_q     <= cfg_err_d;
      if (cfg_we && len_ok) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        for (int i = 0; i < NCH; i++) begin
          hist_q[i]  <= '0;
          since_q[i] <= '0;
          cnt_q[i]   <= '0;
        end
      end else if (grant_any) begin
        hist_q[grant_idx]  <= hist_new;
        // Non-overlapping mode restarts the run length so matched bits are not reused.
        since_q[grant_idx] <= (hit && !overlap_q) ? '0 : since_new;
        if (hit && (cnt_q[grant_idx] != '1)) begin
          cnt_q[grant_idx] <= cnt_q[grant_idx] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_out = '0;
    if (32'(cnt_sel) < NCH) cnt_out = cnt_q[cnt_sel[PTR_W-1:0]];
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: vector tables, hand sequences for multi-cycle corners,
// and random traffic against a stream-level reference model.
module tb_seq_detect_scheduler;
  localparam int NCH      = 4;
  localparam int PLEN_MAX = 8;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_we = 1'b0;
  logic [PLEN_MAX-1:0] cfg_pattern = '0;
  logic [3:0]          cfg_len = '0;
  logic                cfg_overlap = 1'b0;
  logic                cfg_err;
  logic [NCH-1:0]      req_valid = '0;
  logic [NCH-1:0]      req_bit = '0;
  logic [NCH-1:0]      req_ready;
  logic                match_valid;
  logic [2:0]          match_ch;
  logic [2:0]          cnt_sel = '0;
  logic [CNT_W-1:0]    cnt_out;

  always #5 clk = ~clk;

  seq_detect_scheduler #(.NCH(NCH), .PLEN_MAX(PLEN_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(cfg_err), .req_valid(req_valid), .req_bit(req_bit),
    .req_ready(req_ready), .match_valid(match_valid), .match_ch(match_ch),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  typedef struct {
    logic [NCH-1:0] vld;
    logic [NCH-1:0] bits;
    logic [NCH-1:0] exp_rdy;
    logic           exp_mv;
    logic [2:0]     exp_mch;
  } vec_t;
  vec_t tab[$];

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard entries: {cfg_err, match_valid, match_ch} expected one cycle later.
  logic [4:0] exp_q[$];

  // Reference model: per-channel bit stream since last clear, run length, match count.
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ov;
  int         m_ptr;
  int         m_hist [NCH][$];
  int         m_since[NCH];
  int         m_cnt  [NCH];
  int         m_hold;

  logic [NCH-1:0] obs_rdy;
  logic           obs_mv;
  logic [2:0]     obs_mch;
  logic           obs_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat  = 8'b0000_1010;
    m_len  = 4;
    m_ov   = 1'b0;
    m_ptr  = 0;
    m_hold = 0;
    for (int c = 0; c < NCH; c++) begin
      m_hist[c].delete();
      m_since[c] = 0;
      m_cnt[c]   = 0;
    end
    exp_q.delete();
  endtask

  // Called at posedge+1: drive, check at negedge, advance the model, return at next posedge+1.
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic we,
                       input logic [7:0] pat, input logic [3:0] ln, input logic ov,
                       input logic [2:0] sel);
    logic [4:0]     e;
    logic [NCH-1:0] e_rdy;
    int             g, c, n;
    logic           hit, err;
    req_valid = v; req_bit = b; cfg_we = we; cfg_pattern = pat;
    cfg_len = ln; cfg_overlap = ov; cnt_sel = sel;
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b0;
    g = -1;
    if (!we) begin
      for (int i = 0; i < NCH; i++) begin
        c = (m_ptr + i) % NCH;
        if (g < 0 && v[c]) g = c;
      end
    end
    e_rdy = (g >= 0) ? (NCH'(1) << g) : '0;
    obs_rdy = req_ready; obs_mv = match_valid; obs_mch = match_ch; obs_err = cfg_err;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("match_valid", 32'(match_valid), 32'(e[3]));
    chk("match_ch", 32'(match_ch), 32'(e[2:0]));
    chk("cfg_err", 32'(cfg_err), 32'(e[4]));
    chk("cnt_out", 32'(cnt_out), (int'(sel) < NCH) ? 32'(m_cnt[sel]) : 32'd0);
    hit = 1'b0;
    err = 1'b0;
    if (we) begin
      if (ln >= 1 && int'(ln) <= PLEN_MAX) begin
        m_pat = pat; m_len = int'(ln); m_ov = ov; m_ptr = 0;
        for (int k = 0; k < NCH; k++) begin
          m_hist[k].delete(); m_since[k] = 0; m_cnt[k] = 0;
        end
      end else begin
        err = 1'b1;
      end
    end else if (g >= 0) begin
      m_hist[g].push_back(int'(b[g]));
      if (m_hist[g].size() > PLEN_MAX) void'(m_hist[g].pop_front());
      m_since[g]++;
      if (m_since[g] >= m_len) begin
        hit = 1'b1;
        n = m_hist[g].size();
        for (int k = 0; k < m_len; k++) begin
          if (m_hist[g][n-1-k] != int'(m_pat[k])) hit = 1'b0;
        end
      end
      if (hit) begin
        m_hold = g;
        if (!m_ov) m_since[g] = 0;
        if (m_cnt[g] < CNT_MAX) m_cnt[g]++;
      end
      m_ptr = (g + 1) % NCH;
    end
    exp_q.push_back({err, hit, 3'(m_hold)});
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                     input logic [NCH-1:0] r, input logic mv, input logic [2:0] mch);
    vec_t x;
    x.vld = v; x.bits = b; x.exp_rdy = r; x.exp_mv = mv; x.exp_mch = mch;
    tab.push_back(x);
  endtask

  task automatic run_tab(input string tag);
    foreach (tab[i]) begin
      cycle(tab[i].vld, tab[i].bits, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
      chk({tag, "_rdy"}, 32'(obs_rdy), 32'(tab[i].exp_rdy));
      chk({tag, "_mv"}, 32'(obs_mv), 32'(tab[i].exp_mv));
      if (tab[i].exp_mv) chk({tag, "_mch"}, 32'(obs_mch), 32'(tab[i].exp_mch));
    end
    tab.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] s;
    int nm;
    logic [NCH-1:0] v, b;
    logic [3:0] ln;

    // Reset values while valids are asserted
    req_valid = '1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_mv", 32'(match_valid), 32'd0);
    chk("rst_mch", 32'(match_ch), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_cnt", 32'(cnt_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // 1: default 1010 non-overlapping on ch0
    add(4'h1, 4'h1, 4'h1, 0, 0); add(4'h1, 4'h0, 4'h1, 0, 0);
    add(4'h1, 4'h1, 4'h1, 0, 0); add(4'h1, 4'h0, 4'h1, 0, 0);
    add(4'h1, 4'h1, 4'h1, 1, 0); add(4'h1, 4'h0, 4'h1, 0, 0);
    add(4'h0, 4'h0, 4'h0, 0, 0);
    run_tab("t1");
    chk("t1_cnt", 32'(cnt_out), 32'd1);

    // 2: overlapping 1010
    cycle(4'h0, 4'h0, 1'b1, 8'b1010, 4'd4, 1'b1, 3'd0);
    add(4'h1, 4'h1, 4'h1, 0, 0); add(4'h1, 4'h0, 4'h1, 0, 0);
    add(4'h1, 4'h1, 4'h1, 0, 0); add(4'h1, 4'h0, 4'h1, 0, 0);
    add(4'h1, 4'h1, 4'h1, 1, 0); add(4'h1, 4'h0, 4'h1, 0, 0);
    add(4'h0, 4'h0, 4'h0, 1, 0);
    run_tab("t2");
    chk("t2_cnt", 32'(cnt_out), 32'd2);

    // 3: two channels interleaved
    cycle(4'h0, 4'h0, 1'b1, 8'b1010, 4'd4, 1'b0, 3'd0);
    add(4'h3, 4'h3, 4'h1, 0, 0); add(4'h3, 4'h3, 4'h2, 0, 0);
    add(4'h3, 4'h0, 4'h1, 0, 0); add(4'h3, 4'h0, 4'h2, 0, 0);
    add(4'h3, 4'h3, 4'h1, 0, 0); add(4'h3, 4'h3, 4'h2, 0, 0);
    add(4'h3, 4'h0, 4'h1, 0, 0); add(4'h3, 4'h0, 4'h2, 1, 0);
    add(4'h0, 4'h0, 4'h0, 1, 1);
    run_tab("t3");
    cycle(4'h0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    chk("t3_cnt1", 32'(cnt_out), 32'd1);
    cycle(4'h0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
    chk("t3_cnt0", 32'(cnt_out), 32'd1);

    // 4: pointer at 2, all valid then ch3 dropped
    add(4'hF, 4'h0, 4'h4, 0, 0); add(4'hF, 4'h0, 4'h8, 0, 0);
    add(4'hF, 4'h0, 4'h1, 0, 0); add(4'hF, 4'h0, 4'h2, 0, 0);
    add(4'h7, 4'h0, 4'h4, 0, 0); add(4'h7, 4'h0, 4'h1, 0, 0);
    add(4'h7, 4'h0, 4'h2, 0, 0);
    run_tab("t4");

    // 5: rejected writes leave ch2 detection intact
    cycle(4'h4, 4'h4, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
    cycle(4'h4, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
    cycle(4'h0, 4'h0, 1'b1, 8'hFF, 4'd0, 1'b1, 3'd0);
    cycle(4'h4, 4'h4, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
    chk("t5_err_len0", 32'(obs_err), 32'd1);
    cycle(4'h0, 4'h0, 1'b1, 8'h55, 4'd9, 1'b0, 3'd0);
    cycle(4'h4, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
    chk("t5_err_len9", 32'(obs_err), 32'd1);
    cycle(4'h0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd2);
    chk("t5_ch2_mv", 32'(obs_mv), 32'd1);
    chk("t5_ch2_id", 32'(obs_mch), 32'd2);
    chk("t5_cnt2", 32'(cnt_out), 32'd1);
    cycle(4'h0, 4'h0, 1'b1, 8'b110, 4'd3, 1'b0, 3'd0);
    s = 6'b110110;
    nm = 0;
    for (int i = 5; i >= 0; i--) begin
      cycle(4'h1, {3'b000, s[i]}, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
      nm += int'(obs_mv);
    end
    cycle(4'h0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0);
    nm += int'(obs_mv);
    chk("t5_len3_matches", 32'(nm), 32'd2);
    chk("t5_len3_cnt", 32'(cnt_out), 32'd2);

    // 6: saturate ch1 counter
    for (int i = 0; i < 300; i++) begin
      cycle(4'h2, 4'h2, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
      cycle(4'h2, 4'h2, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
      cycle(4'h2, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    end
    cycle(4'h0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    chk("t6_sat", 32'(cnt_out), 32'(CNT_MAX));

    // Reset mid-pattern with a match pulse in flight
    cycle(4'h0, 4'h0, 1'b1, 8'b1010, 4'd4, 1'b0, 3'd1);
    cycle(4'h2, 4'h2, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    cycle(4'h2, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    cycle(4'h2, 4'h2, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    cycle(4'h1, 4'h1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    cycle(4'h1, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    cycle(4'h1, 4'h1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    cycle(4'h2, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1);
    chk("t6_pending", 32'(match_valid), 32'd1);
    req_valid = '1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_mv", 32'(match_valid), 32'd0);
    chk("t6_rst_mch", 32'(match_ch), 32'd0);
    chk("t6_rst_err", 32'(cfg_err), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_cnt", 32'(cnt_out), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    nm = 0;
    cycle(4'h1, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0); nm += int'(obs_mv);
    cycle(4'h1, 4'h1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0); nm += int'(obs_mv);
    cycle(4'h1, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0); nm += int'(obs_mv);
    cycle(4'h0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 3'd0); nm += int'(obs_mv);
    chk("t6_post_rst_matches", 32'(nm), 32'd0);
    chk("t6_post_rst_cnt", 32'(cnt_out), 32'd0);

    // Random traffic with occasional (sometimes illegal) reconfiguration
    for (int i = 0; i < 1500; i++) begin
      v = NCH'($urandom_range(0, 15));
      b = NCH'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        ln = 4'($urandom_range(0, 6));
        if ($urandom_range(0, 7) == 0) ln = 4'($urandom_range(9, 15));
        cycle(v, b, 1'b1, 8'($urandom_range(0, 255)), ln, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)));
      end else begin
        cycle(v, b, 1'b0, 8'h00, 4'd0, 1'b0, 3'($urandom_range(0, 7)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
Shared, programmable serial-pattern detector engine, time-multiplexed across NCH bit-stream requesters. A round-robin arbiter grants one requester's bit per cycle to the single detector datapath. Per-channel detection context (bit history and bits-since-match) is saved and restored so each stream is detected independently. Sits between the serial input channels and the status/interrupt logic. Reset defaults reproduce the team's standard 1010 non-overlapping Moore detector.

Parameters:
NCH, 4, number of requester channels (2..8)
PLEN_MAX, 8, maximum pattern length in bits
CNT_W, 8, width of the per-channel saturating match counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  configuration write strobe
cfg_pattern  input  PLEN_MAX  pattern; the first bit received is compared to cfg_pattern[len-1]
cfg_len  input  4  pattern length; legal range 1..PLEN_MAX
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection
cfg_err  output  1  one-cycle pulse when a write is rejected
req_valid  input  NCH  per-channel bit valid
req_bit  input  NCH  per-channel serial bit
req_ready  output  NCH  one-hot grant; a bit is transferred when valid & ready
match_valid  output  1  registered one-cycle match pulse
match_ch  output  3  channel of the current match
cnt_sel  input  3  counter read select
cnt_out  output  CNT_W  match count of channel cnt_sel (combinational read)

Behaviour:
- Reset (async, rst=1):
  - pattern=4'b1010, len=4, overlap=0.
  - Round-robin pointer = 0.
  - All histories, since-counters and match counters = 0.
  - match_valid=0, match_ch=0, cfg_err=0, req_ready=0.
  - Reset asserted mid-stream discards all in-flight context. A match pending for the next cycle is dropped.
- Arbitration (combinational):
  - req_ready grants the first asserted req_valid at or after the pointer, searching upward with wrap.
  - At most one bit is granted per cycle. req_ready=0 when no valid is asserted.
  - On a grant to channel g, the pointer becomes (g+1) mod NCH at the clock edge. With no grant, the pointer holds.
- Context update on an accepted bit from channel g (single edge):
  - hist[g] = {hist[g][PLEN_MAX-2:0], bit}.
  - since[g] saturates at PLEN_MAX.
- Match condition, evaluated on the updated context:
  - hist_new[len-1:0] == pattern[len-1:0], and
  - since_new >= len.
- On a match:
  - Non-overlapping mode: since[g] is set to 0.
  - Overlapping mode: since[g] is kept.
  - cnt[g] increments and saturates at 2^CNT_W-1.
- Match output latency: a bit accepted at edge N produces match_valid=1 and match_ch=g during the cycle after edge N, for exactly one cycle. match_ch holds its last value otherwise.
- Configuration write (cfg_we=1):
  - req_ready forced to 0 and no bit is accepted that cycle.
  - If cfg_len is in 1..PLEN_MAX: latch pattern, len and overlap; clear all histories, since-counters and match counters; reset the pointer to 0.
  - If cfg_len is out of range: all state is unchanged and cfg_err pulses for one cycle.
  - A match pulse from the previous cycle's bit still appears.
- Counter read:
  - cnt_sel >= NCH returns 0.
  - A read in the same cycle as an increment returns the pre-increment value.

Test Plan:
1. After reset, ch0 only sends 1,0,1,0,1,0 back-to-back:
   - one match_valid, match_ch=0, in the cycle after the 4th bit;
   - cnt_out(sel=0)=1.
2. Write cfg overlap=1 (pattern 1010, len 4), then repeat scenario 1:
   - matches after the 4th and 6th bits;
   - cnt_out=2.
3. ch0 and ch1 valid every cycle, both sending 1,0,1,0:
   - grants alternate 0,1,0,1,…;
   - matches for ch0 then ch1 on consecutive cycles;
   - no cross-channel corruption.
4. All 4 channels valid with pointer=2:
   - grant order 2,3,0,1;
   - dropping ch3's valid gives order 2,0,1.
5. cfg_len=0 and cfg_len=9:
   - cfg_err pulses, state unchanged, detection continues;
   - cfg_len=3 with pattern 3'b110 on stream 1,1,0,1,1,0 (non-overlap) gives 2 matches.
6. Drive 300 matches on ch1: cnt_out saturates at 255. Then:
   - reset asserted mid-pattern (after bits 1,0,1) zeroes all outputs immediately;
   - following bits 0,1,0 produce no match.
